pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register generalising the per-stage control/data latches (IF/ID through MEM/WB) into one reusable block. It carries a control field and a data field, and adds a valid/ready handshake, stall back-pressure, synchronous flush and an optional skid entry. A stalled downstream stage therefore never forces a combinational ready path upstream. One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 101, width of data payload (default = 32 mem data + 32 alu result + 5 dest reg + 32 pc+4)
CTRL_W, 3, width of control payload (default = 2 mem_to_reg + 1 reg_write)
SKID, 1, 1 = two-entry (main + skid) stage with registered in_ready; 0 = single-entry stage with combinational in_ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held entries (branch/jump squash)
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat (0 = stall)
out_ctrl  output  CTRL_W  control field of head entry; all-zero whenever out_valid=0
out_data  output  DATA_W  data field of head entry
occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Reset (async, rst=1): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid entry cleared. in_ready=1 when SKID=1; in_ready=1 when SKID=0 (follows from out_valid=0).
- push = in_valid & in_ready; pop = out_valid & out_ready. All state updates occur on the rising clk edge.
- Latency: an accepted beat appears on out_* on the next edge. Ordering is strictly FIFO.
- SKID=0, single entry:
  - in_ready = ~out_valid | out_ready (combinational).
  - On push, main <= in; on pop without push, out_valid <= 0 and out_ctrl <= 0.
- SKID=1, states EMPTY(0), ONE(1), FULL(2). in_ready is a register, = (state != FULL).
  - EMPTY: push -> ONE, main <= in.
  - ONE:
    - push & pop -> ONE, main <= in.
    - push & ~pop -> FULL, skid <= in.
    - pop & ~push -> EMPTY.
  - FULL: in_ready=0, so no push is possible. pop -> ONE, main <= skid.
  - Holding (no push, no pop): all registers keep their values.
- Bubble rule: when an entry leaves without replacement, its ctrl register is written 0. This ensures a bubble never asserts reg_write or mem_to_reg.
- Flush (flush=1 at edge): next state EMPTY, out_valid=0, out_ctrl=0, skid invalidated.
  - out_data is unchanged (don't care).
  - A beat presented with in_valid=1 in the same cycle is dropped, even if in_ready=1.
  - flush has priority over push and pop. out_ready is ignored for the flush cycle; downstream must not count a pop that cycle.
- Reset asserted mid-operation: immediate return to the reset values regardless of state. After deassertion, the first push is accepted on the first edge.
- occupancy equals the state encoding. With SKID=0 it is {1'b0, out_valid}.
- No arithmetic. Widths pass through unchanged. DATA_W and CTRL_W must be >= 1.

Test Plan:
- Reset and fill: assert rst mid-stream, release; push in_ctrl=3'b101, in_data=101'h1234 with out_ready=1.
  -> out_valid=1, out_ctrl=3'b101, out_data=101'h1234 one edge later; occupancy=1.
- Stall into skid (SKID=1): out_ready=0; push A=ctrl 3'b001, then B=ctrl 3'b010.
  -> occupancy 1 then 2; in_ready=0 after the second edge; out_ctrl holds 3'b001.
  - Then raise out_ready -> A, then B, emitted on consecutive cycles, with no loss or duplication.
- Streaming throughput: in_valid=1, out_ready=1 for 16 cycles with data = 0..15.
  -> out_data 0..15 in order, one per cycle after 1-cycle latency; in_ready stays 1.
- Flush priority: FULL state; assert flush with in_valid=1, out_ready=1.
  -> next cycle occupancy=0, out_valid=0, out_ctrl=0; the incoming beat never appears.
- Bubble control zeroing: push beat with ctrl 3'b111, pop it, no further push.
  -> out_valid=0 and out_ctrl=3'b000 on the following cycle.
- SKID=0 instance: out_valid=1, out_ready=0 -> in_ready=0 combinationally.
  - Set out_ready=1 with in_valid=1 in the same cycle -> pass-through replacement; occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, flush and optional skid entry
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of every held entry; beats offered that cycle are dropped
//   in_valid/in_ready upstream handshake; in_ctrl/in_data carry the beat
//   out_valid/out_ready downstream handshake; out_ctrl/out_data show the head entry
//   occupancy         number of held entries (0, 1, or 2 with SKID=1)
//
// With SKID=1 the stage holds up to two entries and in_ready comes straight from a flop,
// so a downstream stall never reaches upstream through combinational logic. With SKID=0 it is
// a single register whose in_ready looks through to out_ready.

module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              push;
  logic              pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next state and payload. Whenever an entry leaves without a replacement its ctrl is
  // cleared, so a bubble can never carry reg_write or mem_to_reg downstream.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush beats both push and pop; main data is left as-is since it is never shown
      // while out_valid is low.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (push && (SKID != 0)) begin
            // Downstream stalled while upstream still had a beat: park it in the skid entry.
            // Without a skid entry in_ready tracks out_ready here, so this cannot happen.
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // Outputs.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
    occupancy = state_q;
    if (SKID != 0) begin
      in_ready = in_ready_q;
    end else begin
      in_ready = ~out_valid | out_ready;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (SKID=1 and SKID=0 instances)

module tb_pipe_stage_reg;

  localparam int DW = 101;
  localparam int CW = 3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic [1:0]    exp_occ;
    logic          exp_rdy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;

  beat_t qa[$];
  beat_t qb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both instances against their scoreboard queues.
  task automatic check_model(input string tag);
    check($sformatf("%s a_valid", tag), 128'(a_out_valid), 128'(qa.size() != 0));
    check($sformatf("%s a_occ", tag), 128'(a_occ), 128'(qa.size()));
    check($sformatf("%s a_rdy", tag), 128'(a_in_ready), 128'(qa.size() < 2));
    if (qa.size() != 0) begin
      check($sformatf("%s a_ctrl", tag), 128'(a_out_ctrl), 128'(qa[0].ctrl));
      check($sformatf("%s a_data", tag), 128'(a_out_data), 128'(qa[0].data));
    end else begin
      check($sformatf("%s a_bubble_ctrl", tag), 128'(a_out_ctrl), 128'(0));
    end
    check($sformatf("%s b_valid", tag), 128'(b_out_valid), 128'(qb.size() != 0));
    check($sformatf("%s b_occ", tag), 128'(b_occ), 128'(qb.size()));
    check($sformatf("%s b_rdy", tag), 128'(b_in_ready), 128'((qb.size() == 0) || out_ready));
    if (qb.size() != 0) begin
      check($sformatf("%s b_ctrl", tag), 128'(b_out_ctrl), 128'(qb[0].ctrl));
      check($sformatf("%s b_data", tag), 128'(b_out_data), 128'(qb[0].data));
    end else begin
      check($sformatf("%s b_bubble_ctrl", tag), 128'(b_out_ctrl), 128'(0));
    end
  endtask

  // One clock: drive at edge+1, check mid-cycle, update models, advance to next edge+1.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    logic  a_rdy_m;
    logic  b_rdy_m;
    beat_t bt;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #3;
    check_model("pre");
    a_rdy_m = (qa.size() < 2);
    b_rdy_m = (qb.size() == 0) || ordy;
    bt.ctrl = ic;
    bt.data = id;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() != 0 && ordy) qa.delete(0);
      if (iv && a_rdy_m) qa.push_back(bt);
      if (qb.size() != 0 && ordy) qb.delete(0);
      if (iv && b_rdy_m) qb.push_back(bt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[24];

    vt[0]  = '{1'b1, 3'b101, 101'h1234, 1'b1, 1'b0, 2'd1, 1'b1};
    vt[1]  = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[2]  = '{1'b1, 3'b001, 101'hA,    1'b0, 1'b0, 2'd1, 1'b1};
    vt[3]  = '{1'b1, 3'b010, 101'hB,    1'b0, 1'b0, 2'd2, 1'b0};
    vt[4]  = '{1'b1, 3'b111, 101'hC,    1'b0, 1'b0, 2'd2, 1'b0};
    vt[5]  = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd1, 1'b1};
    vt[6]  = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[7]  = '{1'b1, 3'b011, 101'h10,   1'b0, 1'b0, 2'd1, 1'b1};
    vt[8]  = '{1'b1, 3'b100, 101'h11,   1'b0, 1'b0, 2'd2, 1'b0};
    vt[9]  = '{1'b1, 3'b110, 101'h12,   1'b1, 1'b1, 2'd0, 1'b1};
    vt[10] = '{1'b1, 3'b101, 101'h13,   1'b0, 1'b0, 2'd1, 1'b1};
    vt[11] = '{1'b1, 3'b110, 101'h14,   1'b1, 1'b1, 2'd0, 1'b1};
    vt[12] = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[13] = '{1'b1, 3'b111, 101'h77,   1'b1, 1'b0, 2'd1, 1'b1};
    vt[14] = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[15] = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[16] = '{1'b1, 3'b001, 101'h20,   1'b1, 1'b0, 2'd1, 1'b1};
    vt[17] = '{1'b1, 3'b010, 101'h21,   1'b1, 1'b0, 2'd1, 1'b1};
    vt[18] = '{1'b0, 3'b000, 101'h0,    1'b0, 1'b0, 2'd1, 1'b1};
    vt[19] = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};
    vt[20] = '{1'b1, 3'b011, 101'h30,   1'b0, 1'b0, 2'd1, 1'b1};
    vt[21] = '{1'b1, 3'b100, 101'h31,   1'b0, 1'b0, 2'd2, 1'b0};
    vt[22] = '{1'b1, 3'b101, 101'h32,   1'b1, 1'b0, 2'd1, 1'b1};
    vt[23] = '{1'b0, 3'b000, 101'h0,    1'b1, 1'b0, 2'd0, 1'b1};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    @(posedge clk);
    #1;
    check("reset a_valid", 128'(a_out_valid), 128'(0));
    check("reset a_ctrl", 128'(a_out_ctrl), 128'(0));
    check("reset a_data", 128'(a_out_data), 128'(0));
    check("reset a_occ", 128'(a_occ), 128'(0));
    check("reset a_rdy", 128'(a_in_ready), 128'(1));
    check("reset b_rdy", 128'(b_in_ready), 128'(1));
    check("reset b_valid", 128'(b_out_valid), 128'(0));

    // Mid-stream asynchronous reset: fill A to FULL, B to one entry, then reset between edges.
    rst = 1'b0;
    step(1'b1, 3'b011, 101'h55, 1'b0, 1'b0);
    step(1'b1, 3'b110, 101'h66, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst a_occ", 128'(a_occ), 128'(0));
    check("midrst a_valid", 128'(a_out_valid), 128'(0));
    check("midrst a_ctrl", 128'(a_out_ctrl), 128'(0));
    check("midrst a_data", 128'(a_out_data), 128'(0));
    check("midrst a_rdy", 128'(a_in_ready), 128'(1));
    check("midrst b_occ", 128'(b_occ), 128'(0));
    check("midrst b_data", 128'(b_out_data), 128'(0));
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: fill, skid stall, flush priority, bubble zeroing, replacement, FULL pop.
    for (int i = 0; i < 24; i++) begin
      step(vt[i].iv, vt[i].ic, vt[i].id, vt[i].ordy, vt[i].fl);
      check($sformatf("vec%0d occ", i), 128'(a_occ), 128'(vt[i].exp_occ));
      check($sformatf("vec%0d rdy", i), 128'(a_in_ready), 128'(vt[i].exp_rdy));
    end

    // Streaming: one beat per cycle, in_ready never drops.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      check($sformatf("stream%0d rdy", i), 128'(a_in_ready), 128'(1));
      check($sformatf("stream%0d occ", i), 128'(a_occ), 128'(1));
    end
    step(1'b0, 3'b000, 101'h0, 1'b1, 1'b0);
    check("drain a_occ", 128'(a_occ), 128'(0));
    step(1'b0, 3'b000, 101'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
